// File: rtl/param_alu_if.sv
// Operand/result handshake bundle for param_alu_pipe.
// The master drives operands and consumes results; the slave is the ALU.
interface param_alu_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             zero;
  logic             neg;
  logic             ovf;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, carry, zero, neg, ovf
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, carry, zero, neg, ovf
  );
endinterface

// File: rtl/param_alu_pipe.sv
// WIDTH-bit ALU with one registered output stage and valid/ready on both sides.
// Define ALU_ACCUM_EN to add the accumulator register and the ACC_ADD/ACC_CLR ops.
module param_alu_pipe #(
  parameter int WIDTH = 4
) (
  input logic        clk,
  input logic        rst,
  param_alu_if.slave bus
);
  localparam logic [2:0] OP_ADD     = 3'd0;
  localparam logic [2:0] OP_SUB     = 3'd1;
  localparam logic [2:0] OP_XOR     = 3'd2;
  localparam logic [2:0] OP_AND     = 3'd3;
  localparam logic [2:0] OP_OR      = 3'd4;
  localparam logic [2:0] OP_PASSB   = 3'd5;
  localparam logic [2:0] OP_ACC_ADD = 3'd6;
  localparam logic [2:0] OP_ACC_CLR = 3'd7;

  logic             out_valid_q;
  logic [WIDTH-1:0] result_q;
  logic             carry_q;
  logic             zero_q;
  logic             neg_q;
  logic             ovf_q;

  logic             accept;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             cin;
  logic [WIDTH:0]   sum;
  logic             arith;
  logic [WIDTH-1:0] res_d;
  logic             carry_d;
  logic             ovf_d;

`ifdef ALU_ACCUM_EN
  logic [WIDTH-1:0] acc_q;
`endif

  // Handshake: a transfer happens on a rising edge where valid && ready.
  // in_ready = !out_valid || out_ready, so a full register can drain and refill
  // on the same edge; while stalled, result/flags/out_valid hold.
  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  // Shared adder; SUB feeds ~b with carry-in so carry reads as no-borrow.
  always_comb begin
    x   = bus.a;
    y   = bus.b;
    cin = 1'b0;
    case (bus.op)
      OP_SUB: begin
        y   = ~bus.b;
        cin = 1'b1;
      end
`ifdef ALU_ACCUM_EN
      OP_ACC_ADD: x = acc_q;
`endif
      default: ;
    endcase
    sum = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, cin};
  end

  always_comb begin
    res_d = '0;
    arith = 1'b0;
    case (bus.op)
      OP_ADD, OP_SUB: begin
        res_d = sum[WIDTH-1:0];
        arith = 1'b1;
      end
      OP_XOR:   res_d = bus.a ^ bus.b;
      OP_AND:   res_d = bus.a & bus.b;
      OP_OR:    res_d = bus.a | bus.b;
      OP_PASSB: res_d = bus.b;
`ifdef ALU_ACCUM_EN
      OP_ACC_ADD: begin
        res_d = sum[WIDTH-1:0];
        arith = 1'b1;
      end
`endif
      default:  res_d = '0;
    endcase
    carry_d = arith && sum[WIDTH];
    ovf_d   = arith && (x[WIDTH-1] == y[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      result_q    <= res_d;
      carry_q     <= carry_d;
      zero_q      <= (res_d == '0);
      neg_q       <= res_d[WIDTH-1];
      ovf_q       <= ovf_d;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

`ifdef ALU_ACCUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else if (accept && bus.op == OP_ACC_ADD) begin
      acc_q <= res_d;
    end else if (accept && bus.op == OP_ACC_CLR) begin
      acc_q <= '0;
    end
  end
`endif

  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.carry     = carry_q;
  assign bus.zero      = zero_q;
  assign bus.neg       = neg_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_param_alu_pipe.sv
// Scoreboard bench for param_alu_pipe at WIDTH=8; honours ALU_ACCUM_EN like the RTL.
module tb_param_alu_pipe;
  localparam int W  = 8;
  localparam int TO = 50;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  param_alu_if #(.WIDTH(W)) bus ();

  param_alu_pipe #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;
  logic [W+3:0] exp_q[$];
  bit ready_random = 1'b0;
`ifdef ALU_ACCUM_EN
  int acc_m = 0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int sx(input int v);
    return (v >= (1 << (W - 1))) ? v - (1 << W) : v;
  endfunction

  // Reference: unsigned/signed integer arithmetic, packed as {result, carry, zero, neg, ovf}.
  function automatic logic [W+3:0] model(input logic [2:0] op, input int a, input int b);
    int mask = (1 << W) - 1;
    int smax = (1 << (W - 1)) - 1;
    int smin = -(1 << (W - 1));
    int r = 0;
    int c = 0;
    int v = 0;
    int s;
    case (op)
      3'd0: begin
        r = (a + b) & mask;
        c = ((a + b) > mask) ? 1 : 0;
        s = sx(a) + sx(b);
        v = (s > smax || s < smin) ? 1 : 0;
      end
      3'd1: begin
        r = (a - b) & mask;
        c = (a >= b) ? 1 : 0;
        s = sx(a) - sx(b);
        v = (s > smax || s < smin) ? 1 : 0;
      end
      3'd2: r = a ^ b;
      3'd3: r = a & b;
      3'd4: r = a | b;
      3'd5: r = b;
`ifdef ALU_ACCUM_EN
      3'd6: begin
        r = (acc_m + b) & mask;
        c = ((acc_m + b) > mask) ? 1 : 0;
        s = sx(acc_m) + sx(b);
        v = (s > smax || s < smin) ? 1 : 0;
      end
`endif
      default: r = 0;
    endcase
    return {r[W-1:0], c[0], (r == 0), r[W-1], v[0]};
  endfunction

  function automatic logic [W+3:0] dut_out();
    return {bus.result, bus.carry, bus.zero, bus.neg, bus.ovf};
  endfunction

  // Drive one operation (caller sits just after a rising edge); returns wait cycles
  // and whether out_valid was already up in the accept cycle.
  task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      output int waited, output logic ov_seen);
    logic [W+3:0] e;
    bus.in_valid = 1'b1;
    bus.op = op;
    bus.a = a;
    bus.b = b;
    waited = 0;
    ov_seen = 1'b0;
    while (1) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ov_seen = bus.out_valid;
        e = model(op, int'(a), int'(b));
        exp_q.push_back(e);
`ifdef ALU_ACCUM_EN
        if (op == 3'd6) acc_m = int'(e[W+3:4]);
        if (op == 3'd7) acc_m = 0;
`endif
        @(posedge clk);
        #1;
        break;
      end
      @(posedge clk);
      #1;
      waited++;
      if (waited > TO) begin
        tests++;
        fails++;
        $display("FAIL send_timeout: waited %0d cycles, limit %0d", waited, TO);
        break;
      end
    end
    bus.in_valid = 1'b0;
    bus.op = 3'($urandom_range(0, 7));
    bus.a = W'($urandom);
    bus.b = W'($urandom);
  endtask

  task automatic expect_now(input string name, input logic [W+3:0] exp);
    @(negedge clk);
    check(name, {bus.out_valid, dut_out()}, {1'b1, exp});
    @(posedge clk);
    #1;
  endtask

  // Monitor: every delivered result must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_output: got 0x%0h, expected none", dut_out());
      end else begin
        check("scoreboard", dut_out(), exp_q.pop_front());
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (ready_random) bus.out_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    #500000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    int w;
    logic o;
    int n;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.op = '0;
    bus.a = '0;
    bus.b = '0;
    #12;
    check("reset_outputs", {bus.out_valid, dut_out()}, '0);
    check("reset_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    bus.out_ready = 1'b1;
    send(3'd0, 8'hFF, 8'h01, w, o);
    expect_now("add_ff_01", {8'h00, 4'b1100});
    send(3'd1, 8'h80, 8'h01, w, o);
    expect_now("sub_80_01", {8'h7F, 4'b1001});
    send(3'd1, 8'h01, 8'h02, w, o);
    expect_now("sub_01_02", {8'hFF, 4'b0010});

`ifdef ALU_ACCUM_EN
    send(3'd6, 8'h11, 8'h05, w, o);
    expect_now("acc_add_1", {8'h05, 4'b0000});
    send(3'd6, 8'h22, 8'h05, w, o);
    expect_now("acc_add_2", {8'h0A, 4'b0000});
    send(3'd6, 8'h33, 8'h05, w, o);
    expect_now("acc_add_3", {8'h0F, 4'b0000});
    send(3'd7, 8'h44, 8'h66, w, o);
    expect_now("acc_clr", {8'h00, 4'b0100});
    send(3'd6, 8'h55, 8'h80, w, o);
    expect_now("acc_add_80", {8'h80, 4'b0010});
    send(3'd6, 8'h66, 8'h80, w, o);
    expect_now("acc_add_wrap", {8'h00, 4'b1101});
`else
    send(3'd6, 8'h33, 8'h05, w, o);
    expect_now("op6_disabled", {8'h00, 4'b0100});
    send(3'd7, 8'h33, 8'h05, w, o);
    expect_now("op7_disabled", {8'h00, 4'b0100});
`endif

    bus.out_ready = 1'b0;
    send(3'd2, 8'hF0, 8'hFF, w, o);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_hold", {bus.out_valid, bus.result}, {1'b1, 8'h0F});
      check("stall_in_ready", bus.in_ready, 0);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    send(3'd3, 8'h3C, 8'h0F, w, o);
    check("bp_accept_wait", w, 0);
    check("bp_no_bubble", o, 1);
    expect_now("bp_and", {8'h0C, 4'b0000});

    for (int i = 0; i < 4; i++) begin
      send(3'($urandom_range(0, 5)), W'($urandom), W'($urandom), w, o);
      check("b2b_in_ready", w, 0);
      if (i > 0) check("b2b_out_valid", o, 1);
    end
    @(negedge clk);
    check("b2b_last_valid", bus.out_valid, 1);
    @(posedge clk);
    #1;

    ready_random = 1'b1;
    repeat (300) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end else begin
        send(3'($urandom_range(0, 7)), W'($urandom), W'($urandom), w, o);
      end
    end
    ready_random = 1'b0;
    bus.out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < TO) begin
      @(posedge clk);
      n++;
    end
    check("drain_empty", exp_q.size(), 0);
    #1;

    bus.out_ready = 1'b0;
    send(3'd4, 8'h55, 8'hAA, w, o);
    check("pre_reset_valid", bus.out_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_stall", {bus.out_valid, bus.result}, '0);
    exp_q.delete();
`ifdef ALU_ACCUM_EN
    acc_m = 0;
`endif
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_no_represent", bus.out_valid, 0);
    bus.out_ready = 1'b1;
    send(3'd0, 8'h7F, 8'h01, w, o);
    expect_now("post_reset_add", {8'h80, 4'b0011});

    n = 0;
    while (exp_q.size() != 0 && n < TO) begin
      @(posedge clk);
      n++;
    end
    check("final_drain", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
